// File: rtl/tel_pkg.sv
// -----------------------------------------------------------------------------
// tel_pkg
// Shared definitions for the telephone session controller:
//   - tel_state_e : call session states
//   - ASCII constants used by the character classifier and display builders
//   - status_char : one character of the space-padded state-name string
//   - hex_char    : one uppercase hex ASCII digit
// -----------------------------------------------------------------------------
package tel_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RINGING  = 3'd1,
        S_REJECTED = 3'd2,
        S_BUSY     = 3'd3,
        S_CALL     = 3'd4,
        S_COST     = 3'd5
    } tel_state_e;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_TILDE = 8'h7E;
    localparam logic [7:0] ASCII_DEL   = 8'h7F;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;

    // Character idx (0 = leftmost) of the state name, space-padded on the
    // right. Callers loop over idx to build a string of any length; names
    // longer than the display are truncated on the right.
    function automatic logic [7:0] status_char(input tel_state_e st, input int idx);
        logic [63:0] name;
        int          k;
        case (st)
            S_IDLE:     name = "IDLE    ";
            S_RINGING:  name = "RINGING ";
            S_REJECTED: name = "REJECTED";
            S_BUSY:     name = "BUSY    ";
            S_CALL:     name = "CALL    ";
            S_COST:     name = "COST    ";
            default:    name = "IDLE    ";
        endcase
        k = (idx >= 0 && idx < 8) ? idx : 0;
        if (idx >= 0 && idx < 8) begin
            return name[8*(7-k) +: 8];
        end else begin
            return ASCII_SPACE;
        end
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_0 + {4'd0, nib};
        end else begin
            return 8'h37 + {4'd0, nib};   // 0x37 + 10 = 'A'
        end
    endfunction

endpackage

// File: rtl/tel_hex_ascii.sv
// -----------------------------------------------------------------------------
// tel_hex_ascii
// Combinational cost-to-display converter. The cost is rendered as COST_W/4
// uppercase hex digits, right-aligned and zero-padded; all character slots
// above the digits are spaces.
//   cost_i : COST_W-bit value to display
//   hex_o  : 8*MSG_CHARS-bit ASCII string, leftmost character in the MSBs
// -----------------------------------------------------------------------------
module tel_hex_ascii
    import tel_pkg::*;
#(
    parameter int MSG_CHARS = 8,
    parameter int COST_W    = 16
) (
    input  logic [COST_W-1:0]      cost_i,
    output logic [8*MSG_CHARS-1:0] hex_o
);

    localparam int DIGITS = COST_W / 4;

    for (genvar i = 0; i < MSG_CHARS; i++) begin : g_char
        if (i < DIGITS) begin : g_digit
            assign hex_o[8*i +: 8] = hex_char(cost_i[4*i +: 4]);
        end else begin : g_pad
            assign hex_o[8*i +: 8] = ASCII_SPACE;
        end
    end

endmodule

// File: rtl/tel_session_ctrl.sv
// -----------------------------------------------------------------------------
// tel_session_ctrl
// Call session controller between the input debouncers and the 8-character
// ASCII display driver. States: IDLE, RINGING, REJECTED, BUSY, CALL, COST.
// All outputs are registered and derived from the next state, so they always
// describe the state the controller is in during the same cycle.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   startCall  : request a call (IDLE)
//   answerCall : callee answers (RINGING)
//   endCall    : hang up (RINGING, CALL)
//   calleeBusy : callee line busy (RINGING)
//   sendChar   : charSent valid this cycle
//   charSent   : ASCII character
//   statusMsg  : state name, space-padded, leftmost char in MSBs
//   sentMsg    : character history in CALL, hex cost in COST
//   cost       : running charge, saturating
//   costValid  : one-cycle strobe on COST entry
//   callActive : high while in CALL
// -----------------------------------------------------------------------------
module tel_session_ctrl
    import tel_pkg::*;
#(
    parameter int MSG_CHARS   = 8,
    parameter int RING_CYCLES = 10,
    parameter int HOLD_CYCLES = 10,
    parameter int COST_CYCLES = 5,
    parameter int COST_W      = 16,
    parameter int DIGIT_COST  = 1,
    parameter int CHAR_COST   = 2,
    parameter int TICK_CYCLES = 16,
    parameter int TICK_COST   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   startCall,
    input  logic                   answerCall,
    input  logic                   endCall,
    input  logic                   calleeBusy,
    input  logic                   sendChar,
    input  logic [7:0]             charSent,
    output logic [8*MSG_CHARS-1:0] statusMsg,
    output logic [8*MSG_CHARS-1:0] sentMsg,
    output logic [COST_W-1:0]      cost,
    output logic                   costValid,
    output logic                   callActive
);

    localparam int MSG_W   = 8 * MSG_CHARS;
    localparam int MAX_A   = (RING_CYCLES > HOLD_CYCLES) ? RING_CYCLES : HOLD_CYCLES;
    localparam int MAX_T   = (MAX_A > COST_CYCLES) ? MAX_A : COST_CYCLES;
    localparam int TIMER_W = $clog2(MAX_T + 1);
    localparam int TICK_W  = $clog2(TICK_CYCLES + 1);

    localparam logic [TIMER_W-1:0] RING_LAST = TIMER_W'(RING_CYCLES - 1);
    localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] COST_LAST = TIMER_W'(COST_CYCLES - 1);
    localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_CYCLES);

    localparam logic [COST_W-1:0]  COST_MAX   = {COST_W{1'b1}};
    localparam logic [31:0]        DIGIT_AMT  = 32'(DIGIT_COST);
    localparam logic [31:0]        CHAR_AMT   = 32'(CHAR_COST);
    localparam logic [31:0]        TICK_AMT   = 32'(TICK_COST);
    localparam logic [MSG_W-1:0]   ALL_SPACES = {MSG_CHARS{ASCII_SPACE}};

    // Add in a wide domain and clamp, so the accumulator never wraps.
    function automatic logic [COST_W-1:0] sat_add(input logic [COST_W-1:0] a,
                                                  input logic [31:0]       b);
        logic [COST_W+32:0] s;
        s = {33'd0, a} + {{(COST_W+1){1'b0}}, b};
        if (s > {33'd0, COST_MAX}) begin
            return COST_MAX;
        end else begin
            return s[COST_W-1:0];
        end
    endfunction

    tel_state_e          state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [COST_W-1:0]   cost_q, cost_d;
    logic [MSG_W-1:0]    sent_q, sent_d;
    logic [MSG_W-1:0]    status_q, status_d;
    logic                cv_q, cv_d;
    logic                ca_q, ca_d;

    logic                is_digit, is_print, is_del;
    logic                char_ok, tick_now, idle_entry;
    logic [31:0]         charge;
    logic [MSG_W-1:0]    hex_str;

    assign is_digit = (charSent >= ASCII_0) && (charSent <= ASCII_9);
    assign is_print = (charSent >= ASCII_SPACE) && (charSent <= ASCII_TILDE);
    assign is_del   = (charSent == ASCII_DEL);

    // A character counts only in CALL and only when the same cycle is not a
    // hang-up; endCall wins and the character is discarded.
    assign char_ok  = (state_q == S_CALL) && sendChar && !endCall;

    // tick_q numbers the current CALL cycle from 1, wrapping at TICK_CYCLES.
    assign tick_now = (TICK_COST != 0) && (state_q == S_CALL) && (tick_q == TICK_LAST);

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (startCall) state_d = S_RINGING;
            end
            S_RINGING: begin
                if (endCall)                  state_d = S_REJECTED;
                else if (calleeBusy)          state_d = S_BUSY;
                else if (answerCall)          state_d = S_CALL;
                else if (timer_q == RING_LAST) state_d = S_BUSY;
            end
            S_REJECTED, S_BUSY: begin
                if (timer_q == HOLD_LAST) state_d = S_IDLE;
            end
            S_CALL: begin
                if (endCall)                state_d = S_COST;
                else if (sendChar && is_del) state_d = S_COST;
            end
            S_COST: begin
                if (timer_q == COST_LAST) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign idle_entry = (state_d == S_IDLE) && (state_q != S_IDLE);

    // ---------------- counters ----------------
    always_comb begin
        timer_d = (state_d != state_q) ? '0 : timer_q + TIMER_W'(1);
        tick_d  = '0;
        if (state_d == S_CALL) begin
            if (state_q != S_CALL || tick_q == TICK_LAST) tick_d = TICK_W'(1);
            else                                          tick_d = tick_q + TICK_W'(1);
        end
    end

    // ---------------- cost accumulator ----------------
    always_comb begin
        charge = '0;
        if (char_ok) begin
            if (is_digit)               charge = DIGIT_AMT;
            else if (is_print || is_del) charge = CHAR_AMT;
        end
        cost_d = cost_q;
        if (state_q == S_CALL) begin
            cost_d = sat_add(sat_add(cost_q, charge), tick_now ? TICK_AMT : 32'd0);
        end
        if (idle_entry) cost_d = '0;
    end

    tel_hex_ascii #(
        .MSG_CHARS (MSG_CHARS),
        .COST_W    (COST_W)
    ) u_hex (
        .cost_i (cost_d),
        .hex_o  (hex_str)
    );

    // ---------------- display and strobes ----------------
    always_comb begin
        sent_d = sent_q;
        if (char_ok && is_print) sent_d = {sent_q[MSG_W-9:0], charSent};
        if (state_d == S_COST)   sent_d = hex_str;
        if (idle_entry)          sent_d = ALL_SPACES;
    end

    always_comb begin
        status_d = '0;
        for (int i = 0; i < MSG_CHARS; i++) begin
            status_d[MSG_W-1-8*i -: 8] = status_char(state_d, i);
        end
        cv_d = (state_d == S_COST) && (state_q != S_COST);
        ca_d = (state_d == S_CALL);
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            tick_q   <= '0;
            cost_q   <= '0;
            sent_q   <= ALL_SPACES;
            status_q <= {"IDLE", {(MSG_CHARS-4){ASCII_SPACE}}};
            cv_q     <= 1'b0;
            ca_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            tick_q   <= tick_d;
            cost_q   <= cost_d;
            sent_q   <= sent_d;
            status_q <= status_d;
            cv_q     <= cv_d;
            ca_q     <= ca_d;
        end
    end

    assign statusMsg  = status_q;
    assign sentMsg    = sent_q;
    assign cost       = cost_q;
    assign costValid  = cv_q;
    assign callActive = ca_q;

endmodule

// File: tb/tb_tel_session_ctrl.sv
module tb_tel_session_ctrl;

    logic        clk;
    logic        rst, startCall, answerCall, endCall, calleeBusy, sendChar;
    logic [7:0]  charSent;

    logic [63:0] status_a, sent_a, status_b, sent_b, status_c, sent_c;
    logic [15:0] cost_a, cost_c;
    logic [3:0]  cost_b;
    logic        cv_a, ca_a, cv_b, ca_b, cv_c, ca_c;

    int n_cmp = 0;
    int n_bad = 0;

    // Default configuration
    tel_session_ctrl dut_a (
        .clk(clk), .rst(rst), .startCall(startCall), .answerCall(answerCall),
        .endCall(endCall), .calleeBusy(calleeBusy), .sendChar(sendChar),
        .charSent(charSent), .statusMsg(status_a), .sentMsg(sent_a),
        .cost(cost_a), .costValid(cv_a), .callActive(ca_a));

    // Narrow accumulator for saturation
    tel_session_ctrl #(.COST_W(4), .CHAR_COST(2)) dut_b (
        .clk(clk), .rst(rst), .startCall(startCall), .answerCall(answerCall),
        .endCall(endCall), .calleeBusy(calleeBusy), .sendChar(sendChar),
        .charSent(charSent), .statusMsg(status_b), .sentMsg(sent_b),
        .cost(cost_b), .costValid(cv_b), .callActive(ca_b));

    // Duration charging
    tel_session_ctrl #(.TICK_CYCLES(4), .TICK_COST(1)) dut_c (
        .clk(clk), .rst(rst), .startCall(startCall), .answerCall(answerCall),
        .endCall(endCall), .calleeBusy(calleeBusy), .sendChar(sendChar),
        .charSent(charSent), .statusMsg(status_c), .sentMsg(sent_c),
        .cost(cost_c), .costValid(cv_c), .callActive(ca_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, start, answer, endc, busy, send;
        logic [7:0]  ch;
        logic [63:0] st, sent;
        logic [15:0] cost;
        logic        cv, ca;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic s, logic a, logic e, logic b, logic snd,
                                logic [7:0] ch, logic [63:0] st, logic [63:0] sent,
                                logic [15:0] cost, logic cv, logic ca);
        vec_t v;
        v.rst = r; v.start = s; v.answer = a; v.endc = e; v.busy = b; v.send = snd;
        v.ch = ch; v.st = st; v.sent = sent; v.cost = cost; v.cv = cv; v.ca = ca;
        return v;
    endfunction

    task automatic chk_str(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got \"%s\" (%h) expected \"%s\" (%h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic chk_num(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic a, input logic e,
                         input logic b, input logic snd, input logic [7:0] ch);
        rst = r; startCall = s; answerCall = a; endCall = e; calleeBusy = b;
        sendChar = snd; charSent = ch;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        drive(0, 0, 0, 0, 0, 0, 8'h00);
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 8'h00);
        step();
        idle_in();
    endtask

    // Step n cycles with idle inputs, expecting dut_a to show state `exp`.
    task automatic hold_a(input string nm, input int n, input logic [63:0] exp);
        for (int i = 0; i < n; i++) begin
            step();
            chk_str($sformatf("%s[%0d]", nm, i), status_a, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_in();

        // ---- table: answered call, cost display, history shift ----
        //                  rst s a e b snd ch      status      sentMsg     cost cv ca
        tbl.push_back(mk(1,0,0,0,0,0,8'h00,"IDLE    ","        ", 0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,8'h00,"RINGING ","        ", 0,0,0));
        tbl.push_back(mk(0,0,1,0,0,0,8'h00,"CALL    ","        ", 0,0,1));
        tbl.push_back(mk(0,0,0,0,0,1,8'h31,"CALL    ","       1", 1,0,1));
        tbl.push_back(mk(0,0,0,0,0,1,8'h41,"CALL    ","      1A", 3,0,1));
        tbl.push_back(mk(0,0,0,0,0,1,8'h39,"CALL    ","     1A9", 4,0,1));
        tbl.push_back(mk(0,0,0,0,0,1,8'h0A,"CALL    ","     1A9", 4,0,1));
        tbl.push_back(mk(0,0,0,0,0,1,8'h80,"CALL    ","     1A9", 4,0,1));
        tbl.push_back(mk(0,0,0,0,0,1,8'h7F,"COST    ","    0006", 6,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,8'h00,"COST    ","    0006", 6,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,8'h00,"COST    ","    0006", 6,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,8'h00,"COST    ","    0006", 6,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,8'h00,"COST    ","    0006", 6,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,8'h00,"IDLE    ","        ", 0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,8'h00,"RINGING ","        ", 0,0,0));
        tbl.push_back(mk(0,0,1,0,0,0,8'h00,"CALL    ","        ", 0,0,1));
        tbl.push_back(mk(0,0,0,0,0,1,8'h41,"CALL    ","       A", 2,0,1));
        tbl.push_back(mk(0,0,0,0,0,1,8'h42,"CALL    ","      AB", 4,0,1));
        tbl.push_back(mk(0,0,0,0,0,1,8'h43,"CALL    ","     ABC", 6,0,1));
        tbl.push_back(mk(0,0,0,0,0,1,8'h44,"CALL    ","    ABCD", 8,0,1));
        tbl.push_back(mk(0,0,0,0,0,1,8'h45,"CALL    ","   ABCDE",10,0,1));
        tbl.push_back(mk(0,0,0,0,0,1,8'h46,"CALL    ","  ABCDEF",12,0,1));
        tbl.push_back(mk(0,0,0,0,0,1,8'h47,"CALL    "," ABCDEFG",14,0,1));
        tbl.push_back(mk(0,0,0,0,0,1,8'h48,"CALL    ","ABCDEFGH",16,0,1));
        tbl.push_back(mk(0,0,0,0,0,1,8'h49,"CALL    ","BCDEFGHI",18,0,1));
        tbl.push_back(mk(0,0,0,1,0,1,8'h5A,"COST    ","    0012",18,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,8'h00,"COST    ","    0012",18,0,0));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].start, tbl[i].answer, tbl[i].endc,
                  tbl[i].busy, tbl[i].send, tbl[i].ch);
            step();
            chk_str($sformatf("v%0d statusMsg", i), status_a, tbl[i].st);
            chk_str($sformatf("v%0d sentMsg", i), sent_a, tbl[i].sent);
            chk_num($sformatf("v%0d cost", i), 32'(cost_a), 32'(tbl[i].cost));
            chk_num($sformatf("v%0d costValid", i), 32'(cv_a), 32'(tbl[i].cv));
            chk_num($sformatf("v%0d callActive", i), 32'(ca_a), 32'(tbl[i].ca));
        end

        // ---- ring timeout: 10 RINGING, 10 BUSY, back to IDLE ----
        do_reset();
        drive(0, 1, 0, 0, 0, 0, 8'h00);
        step();
        idle_in();
        chk_str("timeout ring[start]", status_a, "RINGING ");
        hold_a("timeout ring", 9, "RINGING ");
        hold_a("timeout busy", 10, "BUSY    ");
        hold_a("timeout idle", 1, "IDLE    ");
        chk_num("timeout cost", 32'(cost_a), 0);

        // ---- endCall beats answerCall in RINGING ----
        do_reset();
        drive(0, 1, 0, 0, 0, 0, 8'h00);
        step();
        idle_in();
        hold_a("reject ring", 2, "RINGING ");
        drive(0, 0, 1, 1, 0, 0, 8'h00);
        step();
        idle_in();
        chk_str("reject entry", status_a, "REJECTED");
        hold_a("reject hold", 9, "REJECTED");
        hold_a("reject idle", 1, "IDLE    ");

        // ---- calleeBusy beats answerCall ----
        do_reset();
        drive(0, 1, 0, 0, 0, 0, 8'h00);
        step();
        drive(0, 0, 1, 0, 1, 0, 8'h00);
        step();
        idle_in();
        chk_str("calleeBusy", status_a, "BUSY    ");
        chk_num("calleeBusy callActive", 32'(ca_a), 0);

        // ---- saturation on a 4-bit accumulator ----
        do_reset();
        drive(0, 1, 0, 0, 0, 0, 8'h00);
        step();
        drive(0, 0, 1, 0, 0, 0, 8'h00);
        step();
        for (int k = 1; k <= 10; k++) begin
            drive(0, 0, 0, 0, 0, 1, 8'h42);
            step();
            chk_num($sformatf("sat cost[%0d]", k), 32'(cost_b), (2*k > 15) ? 15 : 2*k);
        end
        drive(0, 0, 0, 1, 0, 0, 8'h00);
        step();
        idle_in();
        chk_str("sat status", status_b, "COST    ");
        chk_str("sat sentMsg", sent_b, "       F");
        chk_num("sat final cost", 32'(cost_b), 15);
        chk_num("sat costValid", 32'(cv_b), 1);

        // ---- duration ticks: 9 quiet CALL cycles then endCall ----
        do_reset();
        drive(0, 1, 0, 0, 0, 0, 8'h00);
        step();
        drive(0, 0, 1, 0, 0, 0, 8'h00);
        step();
        idle_in();
        chk_num("tick callActive", 32'(ca_c), 1);
        for (int i = 0; i < 9; i++) step();
        drive(0, 0, 0, 1, 0, 0, 8'h00);
        step();
        idle_in();
        chk_str("tick status", status_c, "COST    ");
        chk_num("tick cost", 32'(cost_c), 2);
        chk_str("tick sentMsg", sent_c, "    0002");
        chk_num("tick no-duration cost", 32'(cost_a), 0);

        // ---- reset in the middle of a call ----
        do_reset();
        drive(0, 1, 0, 0, 0, 0, 8'h00);
        step();
        drive(0, 0, 1, 0, 0, 0, 8'h00);
        step();
        drive(0, 0, 0, 0, 0, 1, 8'h58);
        step();
        chk_num("midrst pre cost", 32'(cost_a), 2);
        chk_str("midrst pre sentMsg", sent_a, "       X");
        drive(1, 0, 0, 0, 0, 1, 8'h59);
        step();
        idle_in();
        chk_str("midrst status", status_a, "IDLE    ");
        chk_str("midrst sentMsg", sent_a, "        ");
        chk_num("midrst cost", 32'(cost_a), 0);
        chk_num("midrst callActive", 32'(ca_a), 0);
        chk_num("midrst costValid", 32'(cv_a), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
